// File: rtl/rs232_avm_scheduler.sv
// ---------------------------------------------------------------------------
// rs232_avm_scheduler
//
// Avalon-MM master that owns an RS232 UART slave. It repeatedly polls the
// UART status byte and then moves one byte per poll: either reads a received
// byte into a small RX FIFO, or writes the pending TX holding byte. When both
// directions are serviceable in the same poll, a round-robin priority bit
// decides which one is served.
//
// Optional feature macro: RS232_STATS_EN
//   defined   -> adds rx_count / tx_count transfer counters (16-bit, wrapping)
//   undefined -> counters and their ports are absent
//
// Ports:
//   avm_clk, avm_rst        clock, synchronous active-low reset
//   avm_address/read/write  registered Avalon command (held during waitrequest)
//   avm_writedata           registered write data {24'b0, tx byte}
//   avm_readdata            slave read data, valid when read=1, waitrequest=0
//   avm_waitrequest         slave stall
//   tx_data/valid/ready     client TX byte stream into a 1-entry holding reg
//   rx_data/valid/ready     client RX byte stream out of the show-ahead FIFO
//   rx_count, tx_count      (RS232_STATS_EN only) accepted RX reads / TX writes
// ---------------------------------------------------------------------------
module rs232_avm_scheduler #(
  parameter int unsigned RX_FIFO_DEPTH = 4,
  parameter int unsigned POLL_GAP      = 0,
  parameter int unsigned RX_BASE       = 0,
  parameter int unsigned TX_BASE       = 4,
  parameter int unsigned STATUS_BASE   = 8,
  parameter int unsigned RX_OK_BIT     = 7,
  parameter int unsigned TX_OK_BIT     = 6
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready
`ifdef RS232_STATS_EN
  ,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count
`endif
);

  localparam int unsigned PTR_W = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(RX_FIFO_DEPTH);
  localparam logic [4:0]       RX_ADDR     = 5'(RX_BASE);
  localparam logic [4:0]       TX_ADDR     = 5'(TX_BASE);
  localparam logic [4:0]       STATUS_ADDR = 5'(STATUS_BASE);
  // Reset waits POLL_GAP cycles after the first idle cycle; after a finished
  // transaction the accepting cycle already counts, hence the reload of N-1.
  localparam logic [7:0]       GAP_INIT    = 8'(POLL_GAP);
  localparam logic [7:0]       GAP_RELOAD  = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_STATUS, S_RXREAD, S_TXWRITE} state_e;
  typedef enum logic {PRIO_RX, PRIO_TX} prio_e;

  state_e            state_q, state_d;
  prio_e             prio_q, prio_d;
  logic [7:0]        gap_q, gap_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [4:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        fifo_mem [RX_FIFO_DEPTH];

  logic accept, rx_ok, tx_ok, txn_done, push, pop, tx_clear, fifo_full;
  logic unused_readdata;

  // Only the status bits and the low data byte are meaningful.
  assign unused_readdata = ^avm_readdata;

  // The same command stays asserted while stalled, so a low waitrequest in a
  // bus state is exactly the accept.
  assign accept    = !avm_waitrequest;
  assign fifo_full = (count_q == FULL_CNT);
  assign pop       = (count_q != '0) && rx_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d  = state_q;
    gap_d    = gap_q;
    prio_d   = prio_q;
    rx_ok    = 1'b0;
    tx_ok    = 1'b0;
    txn_done = 1'b0;
    push     = 1'b0;
    tx_clear = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (gap_q == 8'd0) state_d = S_STATUS;
        else               gap_d   = gap_q - 8'd1;
      end
      S_STATUS: begin
        if (accept) begin
          // Fullness is judged here; between now and the push only pops can
          // happen, so the FIFO cannot overflow.
          rx_ok = avm_readdata[RX_OK_BIT] && !fifo_full;
          tx_ok = avm_readdata[TX_OK_BIT] && hold_full_q;
          if (rx_ok && tx_ok) state_d = (prio_q == PRIO_RX) ? S_RXREAD : S_TXWRITE;
          else if (rx_ok)     state_d = S_RXREAD;
          else if (tx_ok)     state_d = S_TXWRITE;
          else                txn_done = 1'b1;
        end
      end
      S_RXREAD: begin
        if (accept) begin
          push     = 1'b1;
          prio_d   = PRIO_TX;
          txn_done = 1'b1;
        end
      end
      S_TXWRITE: begin
        if (accept) begin
          tx_clear = 1'b1;
          prio_d   = PRIO_RX;
          txn_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (txn_done) begin
      if (POLL_GAP == 0) begin
        state_d = S_STATUS;
      end else begin
        state_d = S_IDLE;
        gap_d   = GAP_RELOAD;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered Avalon command, decoded from the next state so the new command
  // appears the cycle after acceptance with no dead cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    read_d  = (state_d == S_STATUS) || (state_d == S_RXREAD);
    write_d = (state_d == S_TXWRITE);
    wdata_d = write_d ? {24'h0, hold_q} : 32'h0;
    unique case (state_d)
      S_RXREAD:  addr_d = RX_ADDR;
      S_TXWRITE: addr_d = TX_ADDR;
      default:   addr_d = STATUS_ADDR;
    endcase
  end

  // -------------------------------------------------------------------------
  // TX holding register and RX FIFO bookkeeping
  // -------------------------------------------------------------------------
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    // Capture only happens while empty, so the byte is frozen during TXWRITE.
    if (tx_clear) begin
      hold_full_d = 1'b0;
      hold_d      = 8'h0;
    end else if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = tx_data;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!avm_rst) begin
      state_q     <= S_IDLE;
      gap_q       <= GAP_INIT;
      prio_q      <= PRIO_RX;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= STATUS_ADDR;
      wdata_q     <= 32'h0;
      hold_q      <= 8'h0;
      hold_full_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      prio_q      <= prio_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the count and pointers
  // are, and rx_data is forced to zero while empty, so stale entries are
  // never visible.
  always_ff @(posedge avm_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= avm_readdata[7:0];
  end

  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign tx_ready      = !hold_full_q;
  assign rx_valid      = (count_q != '0);
  assign rx_data       = rx_valid ? fifo_mem[rd_ptr_q] : 8'h0;

`ifdef RS232_STATS_EN
  logic [15:0] rx_count_q, tx_count_q;

  always_ff @(posedge avm_clk) begin
    if (!avm_rst) begin
      rx_count_q <= 16'h0;
      tx_count_q <= 16'h0;
    end else begin
      if (push)     rx_count_q <= rx_count_q + 16'd1;
      if (tx_clear) tx_count_q <= tx_count_q + 16'd1;
    end
  end

  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;
`endif

endmodule
